// File: rtl/cam_vga_timing_gen.sv
// VGA timing derived from an OV-style camera: divided pixel clock, hc/hs realigned to href,
// frame tracking from vsync/href with line counting, lock detection and a sticky sync error.
module cam_vga_timing_gen #(
  parameter int unsigned H_TOTAL     = 784,
  parameter int unsigned HS_START    = 659,
  parameter int unsigned HS_END      = 739,
  parameter int unsigned PCLK_DIV    = 2,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter bit          RESYNC_HREF = 1'b1,
  parameter int unsigned HC_W        = 10,
  parameter int unsigned VC_W        = 10
) (
  input  logic            Cam_pclk,
  input  logic            Reset,
  input  logic            Cam_vsync,
  input  logic            Cam_href,
  input  logic            clr_err,
  output logic            VGA_Clk,
  output logic            hs,
  output logic            vs,
  output logic            blank,
  output logic            sync,
  output logic [HC_W-1:0] hc,
  output logic [VC_W-1:0] vc,
  output logic            frame_start,
  output logic            locked,
  output logic            sync_err,
  output logic [VC_W-1:0] lines_last,
  output logic [1:0]      o_fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_END = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  localparam int unsigned DIV_HALF = PCLK_DIV / 2;

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_div;
  logic            r_vga_clk;
  logic            r_vsync_d;
  logic            r_href_d;
  logic [HC_W-1:0] r_hc;
  logic            r_hs;
  logic            r_vs;
  logic            r_blank;
  logic [VC_W-1:0] r_vc;
  logic [VC_W-1:0] r_lines_last;
  logic            r_locked;
  logic            r_frame_start;
  logic            r_sync_err;

  logic            w_div_wrap;
  logic            w_pix_en;
  logic            w_vs_rise;
  logic            w_vs_fall;
  logic            w_href_rise;
  logic            w_href_fall;
  logic [HC_W-1:0] w_hc_next;
  logic            w_hs_next;
  logic            w_frame_start;
  logic            w_capture;
  logic [VC_W-1:0] w_vc_counted;

  assign w_div_wrap  = (r_div == 2'(DIV_HALF - 1));
  assign w_pix_en    = w_div_wrap & ~r_vga_clk;
  assign w_vs_rise   = Cam_vsync & ~r_vsync_d;
  assign w_vs_fall   = ~Cam_vsync & r_vsync_d;
  assign w_href_rise = Cam_href & ~r_href_d;
  assign w_href_fall = ~Cam_href & r_href_d;

  always_comb begin
    w_hc_next = r_hc;
    if (RESYNC_HREF && w_href_rise) begin
      w_hc_next = '0;
    end else if (w_pix_en) begin
      w_hc_next = (r_hc == HC_W'(H_TOTAL - 1)) ? '0 : r_hc + HC_W'(1);
    end
  end

  // hs is decoded from the next hc so the registered pulse lines up with hc itself
  assign w_hs_next = ((w_hc_next >= HC_W'(HS_START)) && (w_hc_next < HC_W'(HS_END)))
                     ? HS_POL : ~HS_POL;

  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    case (r_state)
      ST_IDLE:     if (w_vs_rise) w_state_next = ST_WAIT_END;
      ST_WAIT_END: begin
        if (w_vs_fall) begin
          w_state_next  = ST_ACTIVE;
          w_frame_start = 1'b1;
        end
      end
      ST_ACTIVE:   if (w_vs_rise) w_state_next = ST_WAIT_END;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // A line ending on the same cycle as vsync rises is counted before capture
  assign w_vc_counted = ((r_state == ST_ACTIVE) && w_href_fall && (r_vc != '1))
                        ? r_vc + VC_W'(1) : r_vc;
  assign w_capture    = (r_state == ST_ACTIVE) && w_vs_rise;

  always_ff @(posedge Cam_pclk or posedge Reset) begin
    if (Reset) begin
      r_div     <= '0;
      r_vga_clk <= 1'b0;
      r_hc      <= '0;
      r_hs      <= ~HS_POL;
    end else begin
      r_div     <= w_div_wrap ? 2'd0 : r_div + 2'd1;
      r_vga_clk <= w_div_wrap ? ~r_vga_clk : r_vga_clk;
      r_hc      <= w_hc_next;
      r_hs      <= w_hs_next;
    end
  end

  always_ff @(posedge Cam_pclk or posedge Reset) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_vsync_d     <= 1'b0;
      r_href_d      <= 1'b0;
      r_vs          <= ~VS_POL;
      r_blank       <= 1'b0;
      r_vc          <= '0;
      r_lines_last  <= '0;
      r_locked      <= 1'b0;
      r_frame_start <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_vsync_d     <= Cam_vsync;
      r_href_d      <= Cam_href;
      r_vs          <= Cam_vsync ~^ VS_POL;
      r_blank       <= Cam_href & (r_state != ST_IDLE);
      r_frame_start <= w_frame_start;
      r_vc          <= w_frame_start ? '0 : w_vc_counted;
      if (w_capture) begin
        r_lines_last <= w_vc_counted;
        r_locked     <= (w_vc_counted == r_lines_last) && (w_vc_counted != '0);
      end
      // Set wins over clear
      r_sync_err    <= (Cam_href & Cam_vsync) | (r_sync_err & ~clr_err);
    end
  end

  assign VGA_Clk     = r_vga_clk;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign sync        = 1'b0;
  assign hc          = r_hc;
  assign vc          = r_vc;
  assign frame_start = r_frame_start;
  assign locked      = r_locked;
  assign sync_err    = r_sync_err;
  assign lines_last  = r_lines_last;
  assign o_fsm_state = r_state;

endmodule

// File: tb/tb_cam_vga_timing_gen.sv
// Bench for cam_vga_timing_gen: two instances (defaults, and div-4/inverted-polarity/no-resync)
// checked every cycle against an arithmetic model of pixel timing and frame bookkeeping.
module tb_cam_vga_timing_gen;
  localparam int H_TOTAL  = 784;
  localparam int HS_START = 659;
  localparam int HS_END   = 739;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vsync = 1'b0;
  logic href = 1'b0;
  logic clr = 1'b0;
  bit   chk_en = 1'b0;

  logic a_vga_clk, a_hs, a_vs, a_blank, a_sync, a_fs, a_locked, a_err;
  logic [9:0] a_hc, a_vc, a_last;
  logic [1:0] a_st;
  logic b_vga_clk, b_hs, b_vs, b_blank, b_sync, b_fs, b_locked, b_err;
  logic [9:0] b_hc, b_vc, b_last;
  logic [1:0] b_st;

  always #5 clk = ~clk;

  cam_vga_timing_gen dut_a (
    .Cam_pclk(clk), .Reset(rst), .Cam_vsync(vsync), .Cam_href(href), .clr_err(clr),
    .VGA_Clk(a_vga_clk), .hs(a_hs), .vs(a_vs), .blank(a_blank), .sync(a_sync),
    .hc(a_hc), .vc(a_vc), .frame_start(a_fs), .locked(a_locked), .sync_err(a_err),
    .lines_last(a_last), .o_fsm_state(a_st)
  );

  cam_vga_timing_gen #(.PCLK_DIV(4), .HS_POL(1'b1), .VS_POL(1'b1), .RESYNC_HREF(1'b0)) dut_b (
    .Cam_pclk(clk), .Reset(rst), .Cam_vsync(vsync), .Cam_href(href), .clr_err(clr),
    .VGA_Clk(b_vga_clk), .hs(b_hs), .vs(b_vs), .blank(b_blank), .sync(b_sync),
    .hc(b_hc), .vc(b_vc), .frame_start(b_fs), .locked(b_locked), .sync_err(b_err),
    .lines_last(b_last), .o_fsm_state(b_st)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Number of pixel-clock rising edges after n pclk edges with half-period 'half'
  function automatic int rises(input int n, input int half);
    return (n + half) / (2 * half);
  endfunction

  // Behavioural model: pclk edge count, resync anchor, frame bookkeeping
  int m_n = 0, m_anchor = 0, m_vc = 0, m_last = 0;
  bit m_pv = 0, m_ph = 0, m_seen = 0, m_act = 0, m_locked = 0, m_err = 0, m_fs = 0, m_blank = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_anchor = 0; m_vc = 0; m_last = 0;
      m_pv = 0; m_ph = 0; m_seen = 0; m_act = 0;
      m_locked = 0; m_err = 0; m_fs = 0; m_blank = 0;
    end else begin : upd
      bit rv, fv, rh, fh;
      int cap;
      rv = vsync & ~m_pv;
      fv = ~vsync & m_pv;
      rh = href & ~m_ph;
      fh = ~href & m_ph;
      m_n++;
      if (rh) m_anchor = m_n;
      m_blank = href & m_seen;
      m_fs = fv & m_seen;
      cap = m_vc + ((m_act && fh) ? 1 : 0);
      if (cap > 1023) cap = 1023;
      if (m_act && rv) begin
        m_locked = (cap == m_last) && (cap != 0);
        m_last = cap;
      end
      m_vc = (fv && m_seen) ? 0 : cap;
      if (fv && m_seen) m_act = 1;
      else if (rv) m_act = 0;
      if (rv) m_seen = 1;
      m_err = (vsync & href) | (m_err & ~clr);
      m_pv = vsync;
      m_ph = href;
    end
  end

  // Statistics for the literal expectations
  int cyc = 0, fs_cnt = 0, blank_cnt = 0;
  int a_lo_min = 9999, a_lo_max = -1, a_hc_max = -1, b_hi_min = 9999, b_hi_max = -1, b_hc_max = -1;
  int a_last_rise = -1, b_last_rise = -1, a_per = 0, b_per = 0;
  logic a_prev_clk = 1'b0, b_prev_clk = 1'b0;

  always @(negedge clk) begin : cmp
    int hca, hcb;
    if (chk_en) begin
      cyc++;
      hca = (rises(m_n, 1) - rises(m_anchor, 1)) % H_TOTAL;
      hcb = rises(m_n, 2) % H_TOTAL;
      check("a_vga_clk", a_vga_clk, m_n % 2);
      check("a_hc", a_hc, hca);
      check("a_hs", a_hs, (hca >= HS_START && hca < HS_END) ? 0 : 1);
      check("a_vs", a_vs, m_pv ? 0 : 1);
      check("a_blank", a_blank, m_blank);
      check("a_sync", a_sync, 0);
      check("a_frame_start", a_fs, m_fs);
      check("a_vc", a_vc, m_vc);
      check("a_lines_last", a_last, m_last);
      check("a_locked", a_locked, m_locked);
      check("a_sync_err", a_err, m_err);
      check("b_vga_clk", b_vga_clk, (m_n / 2) % 2);
      check("b_hc", b_hc, hcb);
      check("b_hs", b_hs, (hcb >= HS_START && hcb < HS_END) ? 1 : 0);
      check("b_vs", b_vs, m_pv ? 1 : 0);
      check("b_blank", b_blank, m_blank);
      check("b_frame_start", b_fs, m_fs);
      check("b_vc", b_vc, m_vc);
      check("b_lines_last", b_last, m_last);
      check("b_locked", b_locked, m_locked);
      check("b_sync_err", b_err, m_err);
      if (a_fs) fs_cnt++;
      if (a_blank) blank_cnt++;
      if (!a_hs) begin
        if (int'(a_hc) < a_lo_min) a_lo_min = int'(a_hc);
        if (int'(a_hc) > a_lo_max) a_lo_max = int'(a_hc);
      end
      if (b_hs) begin
        if (int'(b_hc) < b_hi_min) b_hi_min = int'(b_hc);
        if (int'(b_hc) > b_hi_max) b_hi_max = int'(b_hc);
      end
      if (int'(a_hc) > a_hc_max) a_hc_max = int'(a_hc);
      if (int'(b_hc) > b_hc_max) b_hc_max = int'(b_hc);
      if (a_vga_clk && !a_prev_clk) begin
        if (a_last_rise >= 0) a_per = cyc - a_last_rise;
        a_last_rise = cyc;
      end
      if (b_vga_clk && !b_prev_clk) begin
        if (b_last_rise >= 0) b_per = cyc - b_last_rise;
        b_last_rise = cyc;
      end
      a_prev_clk = a_vga_clk;
      b_prev_clk = b_vga_clk;
    end
  end

  task automatic vsync_pulse();
    @(negedge clk);
    vsync = 1'b1;
    href  = 1'b0;
    repeat ($urandom_range(3, 8)) @(negedge clk);
    vsync = 1'b0;
    repeat ($urandom_range(2, 5)) @(negedge clk);
  endtask

  task automatic send_lines(input int n, input bit end_on_vsync);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      href = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      href = 1'b0;
      if (end_on_vsync && i == n - 1) vsync = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
  endtask

  int fs0;

  initial begin
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Free-running with href low: both instances wrap at least once
    repeat (3300) @(negedge clk);
    check("a_hs_low_first_hc", a_lo_min, 659);
    check("a_hs_low_last_hc", a_lo_max, 738);
    check("a_hc_max", a_hc_max, 783);
    check("a_vga_clk_period", a_per, 2);
    check("b_hs_high_first_hc", b_hi_min, 659);
    check("b_hs_high_last_hc", b_hi_max, 738);
    check("b_hc_max", b_hc_max, 783);
    check("b_vga_clk_period", b_per, 4);

    // href rising at hc=100 realigns only the resyncing instance
    for (int i = 0; i < 2000 && a_hc != 10'd100; i++) @(negedge clk);
    check("wait_a_hc_100", a_hc, 100);
    href = 1'b1;
    @(negedge clk);
    check("a_hc_after_resync", a_hc, 0);
    repeat ($urandom_range(10, 30)) @(negedge clk);
    href = 1'b0;
    repeat (10) @(negedge clk);

    // Frames: 480, 480 (last line ends as vsync rises), 479
    fs0 = fs_cnt;
    vsync_pulse();
    send_lines(480, 1'b0);
    check("vc_frame1", a_vc, 480);
    vsync_pulse();
    check("lines_last_frame1", a_last, 480);
    check("locked_frame1", a_locked, 0);
    check("vc_cleared", a_vc, 0);
    send_lines(480, 1'b1);
    vsync_pulse();
    check("lines_last_frame2", a_last, 480);
    check("locked_frame2", a_locked, 1);
    send_lines(479, 1'b0);
    vsync_pulse();
    check("lines_last_frame3", a_last, 479);
    check("locked_frame3", a_locked, 0);
    check("frame_start_count", fs_cnt - fs0, 4);

    // Sticky sync error, clear, and set-beats-clear
    @(negedge clk);
    vsync = 1'b1;
    href  = 1'b1;
    @(negedge clk);
    href = 1'b0;
    @(negedge clk);
    check("sync_err_set", a_err, 1);
    repeat ($urandom_range(2, 6)) @(negedge clk);
    check("sync_err_held", a_err, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("sync_err_cleared", a_err, 0);
    href = 1'b1;
    clr  = 1'b1;
    @(negedge clk);
    href = 1'b0;
    clr  = 1'b0;
    check("sync_err_set_priority", a_err, 1);
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    clr   = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-frame
    vsync_pulse();
    send_lines(200, 1'b0);
    check("vc_before_reset", a_vc, 200);
    @(negedge clk);
    href = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_a_hc", a_hc, 0);
    check("rst_a_vc", a_vc, 0);
    check("rst_a_last", a_last, 0);
    check("rst_a_hs", a_hs, 1);
    check("rst_a_vs", a_vs, 1);
    check("rst_a_blank", a_blank, 0);
    check("rst_a_vga_clk", a_vga_clk, 0);
    check("rst_a_locked", a_locked, 0);
    check("rst_b_hs", b_hs, 0);
    check("rst_b_vs", b_vs, 0);
    repeat (2) @(negedge clk);
    href = 1'b0;
    rst  = 1'b0;
    blank_cnt = 0;
    send_lines(5, 1'b0);
    check("blank_held_after_reset", blank_cnt, 0);
    vsync_pulse();
    @(negedge clk);
    href = 1'b1;
    @(negedge clk);
    check("blank_follows_href", a_blank, 1);
    send_lines(3, 1'b0);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
